// File: rtl/data_ram_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_sized
// Description : Clocked big-endian byte-addressed data memory with byte/half/
//               word access, load extension, registered reads and fault pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_sized #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  mRD,
    input  logic                  mWR,
    input  logic [1:0]            mSize,
    input  logic                  mSigned,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  AddrErr
);

    localparam int          c_ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] c_DEPTH_EXT  = 33'(DEPTH);
    localparam logic [1:0]  c_SIZE_BYTE  = 2'b00;
    localparam logic [1:0]  c_SIZE_HALF  = 2'b01;
    localparam logic [1:0]  c_SIZE_WORD  = 2'b10;

    // Parameter legality is enforced at elaboration time.
    generate
        if (DATA_WIDTH != 32) begin : g_badDataWidth
            $error("data_ram_sized: DATA_WIDTH must be 32");
        end
        if ((DEPTH < 4) || ((DEPTH % 4) != 0)) begin : g_badDepth
            $error("data_ram_sized: DEPTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic [7:0]          r_ram [DEPTH];

    logic [32:0]         w_nBytes;
    logic [32:0]         w_endAddr;
    logic                w_illegalSize;
    logic                w_misaligned;
    logic                w_outOfRange;
    logic                w_fault;
    logic [c_ADDR_W-1:0] w_idx0;
    logic [c_ADDR_W-1:0] w_idx1;
    logic [c_ADDR_W-1:0] w_idx2;
    logic [c_ADDR_W-1:0] w_idx3;
    logic [7:0]          w_byte0;
    logic [7:0]          w_byte1;
    logic [7:0]          w_byte2;
    logic [7:0]          w_byte3;
    logic                w_ext;
    logic [31:0]         w_loadData;

    // Guards the higher lanes of a sub-word read when DEPTH is not a power of two.
    function automatic logic [7:0] readByte(input logic [c_ADDR_W-1:0] idx);
        if (int'(idx) < DEPTH) begin
            return r_ram[idx];
        end
        return 8'h00;
    endfunction

    always_comb begin
        w_nBytes      = 33'd4;
        w_illegalSize = 1'b0;
        w_misaligned  = 1'b0;
        case (mSize)
            c_SIZE_BYTE: w_nBytes = 33'd1;
            c_SIZE_HALF: begin
                w_nBytes     = 33'd2;
                w_misaligned = Address[0];
            end
            c_SIZE_WORD: begin
                w_nBytes     = 33'd4;
                w_misaligned = (Address[1:0] != 2'b00);
            end
            default: w_illegalSize = 1'b1;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap into range.
        w_endAddr    = {1'b0, Address} + w_nBytes;
        w_outOfRange = (w_endAddr > c_DEPTH_EXT);
        w_fault      = w_illegalSize | w_misaligned | w_outOfRange;
    end

    assign w_idx0 = Address[c_ADDR_W-1:0];
    assign w_idx1 = w_idx0 + c_ADDR_W'(1);
    assign w_idx2 = w_idx0 + c_ADDR_W'(2);
    assign w_idx3 = w_idx0 + c_ADDR_W'(3);

    assign w_byte0 = readByte(w_idx0);
    assign w_byte1 = readByte(w_idx1);
    assign w_byte2 = readByte(w_idx2);
    assign w_byte3 = readByte(w_idx3);

    always_comb begin
        w_ext      = 1'b0;
        w_loadData = {w_byte0, w_byte1, w_byte2, w_byte3};
        case (mSize)
            c_SIZE_BYTE: begin
                w_ext      = mSigned & w_byte0[7];
                w_loadData = {{24{w_ext}}, w_byte0};
            end
            c_SIZE_HALF: begin
                w_ext      = mSigned & w_byte0[7];
                w_loadData = {{16{w_ext}}, w_byte0, w_byte1};
            end
            default: w_loadData = {w_byte0, w_byte1, w_byte2, w_byte3};
        endcase
    end

    // Storage is never reset; stores are suppressed on reset edges and faults.
    always_ff @(posedge CLK) begin
        if (!Reset && mWR && !w_fault) begin
            case (mSize)
                c_SIZE_BYTE: r_ram[w_idx0] <= DataIn[7:0];
                c_SIZE_HALF: begin
                    r_ram[w_idx0] <= DataIn[15:8];
                    r_ram[w_idx1] <= DataIn[7:0];
                end
                c_SIZE_WORD: begin
                    r_ram[w_idx0] <= DataIn[31:24];
                    r_ram[w_idx1] <= DataIn[23:16];
                    r_ram[w_idx2] <= DataIn[15:8];
                    r_ram[w_idx3] <= DataIn[7:0];
                end
                default: ;
            endcase
        end
    end

    // Read data is sampled from the pre-write array, giving read-before-write.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            DataValid <= 1'b0;
            AddrErr   <= 1'b0;
            if (mRD || mWR) begin
                if (w_fault) begin
                    AddrErr <= 1'b1;
                end else if (mRD) begin
                    DataOut   <= w_loadData;
                    DataValid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_sized.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_sized
// Description : Directed self-checking bench for data_ram_sized.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_sized;

    localparam int c_DEPTH = 64;

    logic        CLK;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        mRD;
    logic        mWR;
    logic [1:0]  mSize;
    logic        mSigned;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        AddrErr;

    int passCount  = 0;
    int checkCount = 0;

    data_ram_sized #(.DEPTH(c_DEPTH), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .Address(Address), .DataIn(DataIn),
        .mRD(mRD), .mWR(mWR), .mSize(mSize), .mSigned(mSigned),
        .DataOut(DataOut), .DataValid(DataValid), .AddrErr(AddrErr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Presents one request for a single edge, then returns 1 time unit after it.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] data);
        mRD = rd; mWR = wr; mSize = sz; mSigned = sgn; Address = addr; DataIn = data;
        @(posedge CLK);
        #1;
        mRD = 1'b0; mWR = 1'b0;
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; mRD = 1'b0; mWR = 1'b1; mSize = 2'b10; mSigned = 1'b0;
        Address = 32'd0; DataIn = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLK);
        #1;
        checkCount++;
        if (DataOut !== 32'h0) $display("FAIL reset_dataout: got %h expected %h", DataOut, 32'h0);
        else passCount++;
        checkCount++;
        if (DataValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", DataValid);
        else passCount++;
        checkCount++;
        if (AddrErr !== 1'b0) $display("FAIL reset_addrerr: got %b expected 0", AddrErr);
        else passCount++;
        Reset = 1'b0; mWR = 1'b0;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        checkCount++;
        if (DataOut === 32'hFFFF_FFFF) $display("FAIL reset_no_write: got %h expected not %h", DataOut, 32'hFFFF_FFFF);
        else passCount++;
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'h1122_3344);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        checkCount++;
        if (DataOut !== 32'h1122_3344) $display("FAIL reset_readback: got %h expected %h", DataOut, 32'h1122_3344);
        else passCount++;
    endtask

    task automatic test_sized_writes();
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd8,  32'h8899_AABB);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd9,  32'h0000_0055);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'd10, 32'h0000_CCDD);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd8,  32'h0);
        checkCount++;
        if (DataOut !== 32'h8855_CCDD || DataValid !== 1'b1)
            $display("FAIL word_merge: got %h/%b expected %h/1", DataOut, DataValid, 32'h8855_CCDD);
        else passCount++;
        idle();
        checkCount++;
        if (DataValid !== 1'b0 || DataOut !== 32'h8855_CCDD)
            $display("FAIL valid_one_cycle: got %b/%h expected 0/%h", DataValid, DataOut, 32'h8855_CCDD);
        else passCount++;
    endtask

    task automatic test_extension();
        logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sgn [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] adr [5] = '{32'd8, 32'd8, 32'd8, 32'd10, 32'd9};
        logic [31:0] exp [5] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8855,
                                 32'h0000_CCDD, 32'h0000_0055};
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 1'b0, sz[i], sgn[i], adr[i], 32'h0);
            checkCount++;
            if (DataOut !== exp[i] || DataValid !== 1'b1)
                $display("FAIL load_ext[%0d]: got %h/%b expected %h/1", i, DataOut, DataValid, exp[i]);
            else passCount++;
        end
    endtask

    task automatic test_faults();
        logic [31:0] held;
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'h0123_4567);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        held = 32'h0123_4567;
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'd5, 32'h0);
        checkCount++;
        if (AddrErr !== 1'b1 || DataValid !== 1'b0 || DataOut !== held)
            $display("FAIL half_misaligned: got %b/%b/%h expected 1/0/%h", AddrErr, DataValid, DataOut, held);
        else passCount++;
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd6, 32'hDEAD_BEEF);
        checkCount++;
        if (AddrErr !== 1'b1) $display("FAIL word_misaligned_wr: got %b expected 1", AddrErr);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        checkCount++;
        if (DataOut !== 32'h0123_4567 || AddrErr !== 1'b0)
            $display("FAIL fault_no_write_lo: got %h/%b expected %h/0", DataOut, AddrErr, 32'h0123_4567);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        checkCount++;
        if (DataOut !== 32'h8855_CCDD) $display("FAIL fault_no_write_hi: got %h expected %h", DataOut, 32'h8855_CCDD);
        else passCount++;
        access(1'b1, 1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
        checkCount++;
        if (AddrErr !== 1'b1 || DataValid !== 1'b0)
            $display("FAIL illegal_size: got %b/%b expected 1/0", AddrErr, DataValid);
        else passCount++;
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'(c_DEPTH - 4), 32'hCAFE_F00D);
        checkCount++;
        if (AddrErr !== 1'b0) $display("FAIL top_word_wr: got %b expected 0", AddrErr);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'(c_DEPTH - 4), 32'h0);
        checkCount++;
        if (DataOut !== 32'hCAFE_F00D || DataValid !== 1'b1 || AddrErr !== 1'b0)
            $display("FAIL top_word_rd: got %h/%b/%b expected %h/1/0", DataOut, DataValid, AddrErr, 32'hCAFE_F00D);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'(c_DEPTH), 32'h0);
        checkCount++;
        if (AddrErr !== 1'b1 || DataOut !== 32'hCAFE_F00D)
            $display("FAIL word_at_depth: got %b/%h expected 1/%h", AddrErr, DataOut, 32'hCAFE_F00D);
        else passCount++;
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'(c_DEPTH - 1), 32'h0000_1234);
        checkCount++;
        if (AddrErr !== 1'b1) $display("FAIL half_past_end: got %b expected 1", AddrErr);
        else passCount++;
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0);
        checkCount++;
        if (AddrErr !== 1'b1 || DataValid !== 1'b0)
            $display("FAIL byte_wrap: got %b/%b expected 1/0", AddrErr, DataValid);
        else passCount++;
    endtask

    task automatic test_read_before_write();
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd16, 32'h0102_0304);
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'd16, 32'hA0B0_C0D0);
        checkCount++;
        if (DataOut !== 32'h0102_0304 || DataValid !== 1'b1)
            $display("FAIL rbw_old: got %h/%b expected %h/1", DataOut, DataValid, 32'h0102_0304);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0);
        checkCount++;
        if (DataOut !== 32'hA0B0_C0D0) $display("FAIL rbw_new: got %h expected %h", DataOut, 32'hA0B0_C0D0);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr [3] = '{32'd8, 32'd4, 32'd16};
        logic [31:0] exp [3] = '{32'h8855_CCDD, 32'h0123_4567, 32'hA0B0_C0D0};
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 2'b10, 1'b0, adr[i], 32'h0);
            checkCount++;
            if (DataOut !== exp[i] || DataValid !== 1'b1)
                $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, DataOut, DataValid, exp[i]);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_op();
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        checkCount++;
        if (DataValid !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", DataValid);
        else passCount++;
        Reset = 1'b1;
        idle();
        checkCount++;
        if (DataValid !== 1'b0 || AddrErr !== 1'b0 || DataOut !== 32'h0)
            $display("FAIL reset_after_read: got %b/%b/%h expected 0/0/0", DataValid, AddrErr, DataOut);
        else passCount++;
        Reset = 1'b0;
        access(1'b1, 1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
        Reset = 1'b1;
        mWR = 1'b1; mSize = 2'b10; Address = 32'd16; DataIn = 32'hFFFF_FFFF;
        idle();
        Reset = 1'b0; mWR = 1'b0;
        checkCount++;
        if (AddrErr !== 1'b0) $display("FAIL reset_clears_err: got %b expected 0", AddrErr);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0);
        checkCount++;
        if (DataOut !== 32'hA0B0_C0D0) $display("FAIL mem_after_reset: got %h expected %h", DataOut, 32'hA0B0_C0D0);
        else passCount++;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        checkCount++;
        if (DataOut !== 32'h8855_CCDD) $display("FAIL mem_after_reset2: got %h expected %h", DataOut, 32'h8855_CCDD);
        else passCount++;
    endtask

    initial begin
        Reset = 1'b1; mRD = 1'b0; mWR = 1'b0; mSize = 2'b00; mSigned = 1'b0;
        Address = 32'd0; DataIn = 32'd0;
        test_reset();
        test_sized_writes();
        test_extension();
        test_faults();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
